adpcm_delay: RTL and testbench
==============================

# adpcm_delay

Per-channel unit-sample delay (z⁻¹) for the multi-channel ADPCM codec datapath. It holds one stored word per channel and returns the value written for that channel on the previous sample. Predictor/adaptation blocks use it wherever they need a previous-sample value, with time-multiplexed channel access. Scan ports are present so DFT insertion can stitch five chains; the RTL itself is purely functional.

## Interface
Parameters:
- WIDTH, 16: data word width.
- CHANNELS, 32: number of independent channels (1..256).
- RESET_VALUE, 0: value every channel holds after reset (WIDTH bits).
- CH_W, $clog2(CHANNELS) (min 1): channel index width.

Ports:
- clk  in  1  single system clock; all state on rising edge.
- reset  in  1  synchronous, active-high reset.
- en  in  1  sample strobe; store din into channel ch this cycle.
- ch  in  CH_W  channel index for both read and write.
- din  in  WIDTH  current-sample value to store.
- dout  out  WIDTH  previous-sample value of channel ch (combinational read).
- scan_in0..scan_in4  in  1 each  scan chain inputs; functionally unused.
- scan_enable  in  1  scan shift enable; functionally unused.
- test_mode  in  1  DFT test mode; functionally unused.
- scan_out0..scan_out4  out  1 each  scan chain outputs; RTL drives 1'b0, and the DFT flow replaces them.

## Operation
- Storage: CHANNELS × WIDTH register array mem.
- Reset (reset=1 at a clock edge): every mem entry becomes RESET_VALUE. Reset has priority over en.
- Write: with reset=0, en=1 and ch<CHANNELS at an edge, mem[ch] is set to din.
- en=0: no state change.
- Read: dout = mem[ch] when ch<CHANNELS, otherwise RESET_VALUE. dout is purely combinational from ch and the array.
- Out-of-range ch (possible when CHANNELS is not a power of two): writes are ignored and dout=RESET_VALUE.
- Same-cycle read/write of one channel: dout shows the pre-write (old) value for that cycle. This is the z⁻¹ semantics.
- No arithmetic. Values pass through bit-exact, with no sign or width conversion.
- Scan inputs never affect functional state in RTL.

## Timing
- Write latency: a value written at edge N is visible on dout from just after edge N whenever that channel is addressed.
- Delay semantics: for a given channel, dout during its sample-k access equals the din written at its sample-(k-1) access.
- After reset is released, the first access to each channel reads RESET_VALUE.
- Reset asserted mid-stream clears all channels at that edge. A write requested in the same cycle is lost.
- dout must settle within one clock period from a ch change (mux path only).
- No handshake. en is a single-cycle qualifier, and back-to-back writes on any channels are allowed every cycle.

## Structure
- Shared package adpcm_pkg:
  - default WIDTH and CHANNELS constants;
  - channel-index typedef;
  - per-instance reset constants for delay users (e.g. floating-point DQ init 32, SR init 32, YU init 544).
- Natural sub-module: adpcm_delay_cell, one WIDTH-bit register with sync reset-to-RESET_VALUE and write enable. It is instantiated CHANNELS times via generate.
- Top level contains:
  - write-enable decode per channel;
  - read mux with out-of-range default;
  - scan_out tie-offs.

## Test plan
Run with WIDTH=16, CHANNELS=32, RESET_VALUE=16'h0220 unless noted.
- Reset, then sweep ch 0..31 with en=0 -> dout=16'h0220 on every channel.
- Write ch=5 din=16'h1234 -> same cycle dout = old value 16'h0220. Next cycle with ch=5 -> dout=16'h1234. Other channels stay 16'h0220.
- Write all 32 channels with din=ch*16'h0101 in consecutive cycles, then read back -> each channel returns its own value with no cross-talk. A second pass writing din+1 returns the first-pass values during the write cycle.
- Assert reset and en together with ch=3, din=16'hFFFF -> ch 3 reads 16'h0220. Reset after writes -> all channels read 16'h0220.
- With CHANNELS=24 (CH_W=5): write ch=30 din=16'hAAAA -> dout=16'h0220 and no channel 0..23 changes.
- Toggle scan_in0..4, scan_enable and test_mode randomly during a write/read sequence -> functional results identical to the above, and scan_out0..4 stay 0.

Source files
------------

// File: rtl/adpcm_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : adpcm_pkg
//  Description : Shared constants and types for the ADPCM codec datapath:
//                default word/channel sizing, the channel-index type and the
//                reset values used by the various per-channel delay users.
//  Revision    : 1.0  initial release
// ============================================================================
package adpcm_pkg;

  // Default datapath sizing
  localparam int DEFAULT_WIDTH    = 16;
  localparam int DEFAULT_CHANNELS = 32;
  localparam int DEFAULT_CH_W     = (DEFAULT_CHANNELS > 1) ? $clog2(DEFAULT_CHANNELS) : 1;

  // Channel index for the default channel count
  typedef logic [DEFAULT_CH_W-1:0] ch_idx_t;

  // Reset values for the individual delay instances in the codec
  localparam logic [DEFAULT_WIDTH-1:0] DQ_INIT = 16'd32;   // floating-point DQ
  localparam logic [DEFAULT_WIDTH-1:0] SR_INIT = 16'd32;   // reconstructed signal
  localparam logic [DEFAULT_WIDTH-1:0] YU_INIT = 16'd544;  // fast quantizer scale

  // Index width for an arbitrary channel count, never narrower than one bit
  function automatic int ch_width(input int channels);
    return (channels > 1) ? $clog2(channels) : 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/adpcm_delay_cell.sv
`default_nettype none
// ============================================================================
//  Module      : adpcm_delay_cell
//  Description : One WIDTH-bit storage word with synchronous reset to
//                RESET_VALUE and a write enable. One cell per channel.
//  Revision    : 1.0  initial release
// ============================================================================
module adpcm_delay_cell #(
  parameter int               WIDTH       = 16,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             we,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] data_q;
  logic [WIDTH-1:0] data_d;

  // Next value: take the new sample when written, otherwise hold
  always_comb begin
    data_d = data_q;
    if (we) begin
      data_d = din;
    end
  end

  // Storage register; reset wins over a simultaneous write
  always_ff @(posedge clk) begin
    if (reset) begin
      data_q <= RESET_VALUE;
    end else begin
      data_q <= data_d;
    end
  end

  assign q = data_q;

endmodule
`default_nettype wire

// File: rtl/adpcm_delay.sv
`default_nettype none
// ============================================================================
//  Module      : adpcm_delay
//  Description : Per-channel unit-sample delay (z^-1). Each channel keeps the
//                word written on its previous sample; reads are combinational
//                and therefore return the pre-write value in a write cycle.
//                Scan ports exist only for DFT stitching.
//  Revision    : 1.0  initial release
// ============================================================================
module adpcm_delay
  import adpcm_pkg::*;
#(
  parameter int               WIDTH       = DEFAULT_WIDTH,
  parameter int               CHANNELS    = DEFAULT_CHANNELS,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0,
  parameter int               CH_W        = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic [CH_W-1:0]  ch,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  input  logic             scan_in0,
  input  logic             scan_in1,
  input  logic             scan_in2,
  input  logic             scan_in3,
  input  logic             scan_in4,
  input  logic             scan_enable,
  input  logic             test_mode,
  output logic             scan_out0,
  output logic             scan_out1,
  output logic             scan_out2,
  output logic             scan_out3,
  output logic             scan_out4
);

  logic [WIDTH-1:0] mem [CHANNELS];
  logic [CHANNELS-1:0] wr_en;
  logic [WIDTH-1:0] read_data;

  // One storage cell per channel; an out-of-range ch matches no decode term,
  // so such writes fall away naturally
  generate
    for (genvar i = 0; i < CHANNELS; i++) begin : g_cell
      assign wr_en[i] = en && (ch == CH_W'(i));

      adpcm_delay_cell #(
        .WIDTH       (WIDTH),
        .RESET_VALUE (RESET_VALUE)
      ) u_cell (
        .clk   (clk),
        .reset (reset),
        .we    (wr_en[i]),
        .din   (din),
        .q     (mem[i])
      );
    end
  endgenerate

  // Read mux: stored word of the addressed channel, RESET_VALUE when out of range
  always_comb begin
    read_data = RESET_VALUE;
    for (int i = 0; i < CHANNELS; i++) begin
      if (ch == CH_W'(i)) begin
        read_data = mem[i];
      end
    end
  end

  assign dout = read_data;

  // Scan chains are stitched by the DFT flow; functionally they are ties
  assign scan_out0 = 1'b0;
  assign scan_out1 = 1'b0;
  assign scan_out2 = 1'b0;
  assign scan_out3 = 1'b0;
  assign scan_out4 = 1'b0;

  logic unused_scan;
  assign unused_scan = ^{scan_in0, scan_in1, scan_in2, scan_in3, scan_in4,
                         scan_enable, test_mode};

endmodule
`default_nettype wire

// File: tb/tb_adpcm_delay.sv
`default_nettype none
// ============================================================================
//  Module      : tb_adpcm_delay
//  Description : Bench for adpcm_delay. Two instances (32 and 24 channels)
//                share stimulus; a per-channel array model tracks what each
//                channel must return, compared every cycle, plus literal
//                expectations at key points.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_adpcm_delay;

  localparam int              WIDTH = 16;
  localparam logic [15:0]     RV    = 16'h0220;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        en = 1'b0;
  logic [4:0]  ch = '0;
  logic [15:0] din = '0;
  logic [4:0]  scan_in = '0;
  logic        scan_enable = 1'b0;
  logic        test_mode = 1'b0;

  logic [15:0] dout32, dout24;
  logic [4:0]  so32, so24;

  int checks = 0;
  int errors = 0;
  bit chk_on = 1'b0;

  logic [15:0] m32 [32];
  logic [15:0] m24 [24];

  always #5 clk = ~clk;

  adpcm_delay #(.WIDTH(WIDTH), .CHANNELS(32), .RESET_VALUE(RV)) dut32 (
    .clk(clk), .reset(reset), .en(en), .ch(ch), .din(din), .dout(dout32),
    .scan_in0(scan_in[0]), .scan_in1(scan_in[1]), .scan_in2(scan_in[2]),
    .scan_in3(scan_in[3]), .scan_in4(scan_in[4]),
    .scan_enable(scan_enable), .test_mode(test_mode),
    .scan_out0(so32[0]), .scan_out1(so32[1]), .scan_out2(so32[2]),
    .scan_out3(so32[3]), .scan_out4(so32[4])
  );

  adpcm_delay #(.WIDTH(WIDTH), .CHANNELS(24), .RESET_VALUE(RV)) dut24 (
    .clk(clk), .reset(reset), .en(en), .ch(ch), .din(din), .dout(dout24),
    .scan_in0(scan_in[0]), .scan_in1(scan_in[1]), .scan_in2(scan_in[2]),
    .scan_in3(scan_in[3]), .scan_in4(scan_in[4]),
    .scan_enable(scan_enable), .test_mode(test_mode),
    .scan_out0(so24[0]), .scan_out1(so24[1]), .scan_out2(so24[2]),
    .scan_out3(so24[3]), .scan_out4(so24[4])
  );

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s ch=%0d got=%h expected=%h at %0t", name, ch, act, exp, $time);
    end
  endtask

  // Model: a channel holds whatever was last written to it, reset fills all
  always @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 32; i++) m32[i] <= RV;
      for (int i = 0; i < 24; i++) m24[i] <= RV;
    end else if (en) begin
      m32[ch] <= din;
      if (int'(ch) < 24) m24[ch] <= din;
    end
  end

  // Compare every cycle mid-period once the model is defined
  always @(negedge clk) begin
    if (chk_on) begin
      check("model32", dout32, m32[ch]);
      check("model24", dout24, (int'(ch) < 24) ? m24[ch] : RV);
      check("scan_out", {6'd0, so32, so24}, 16'h0000);
    end
  end

  task automatic drive(input logic r, input logic e, input int c, input logic [15:0] d);
    @(posedge clk);
    #1;
    reset = r;
    en    = e;
    ch    = 5'(c);
    din   = d;
  endtask

  initial begin
    logic [15:0] v;
    // Reset
    drive(1, 0, 0, 16'h0);
    @(posedge clk);
    #1;
    chk_on = 1'b1;
    reset  = 1'b0;

    // Every channel reads the reset value
    for (int c = 0; c < 32; c++) begin
      drive(0, 0, c, 16'h0);
      #1 check("reset_sweep", dout32, 16'h0220);
    end

    // Single write: old value in the write cycle, new value afterwards
    drive(0, 1, 5, 16'h1234);
    #1 check("wr5_same_cycle", dout32, 16'h0220);
    drive(0, 0, 5, 16'h0);
    #1 check("wr5_next_cycle", dout32, 16'h1234);
    drive(0, 0, 6, 16'h0);
    #1 check("ch6_untouched", dout32, 16'h0220);

    // Fill all channels, then a second pass that must see the first pass
    for (int c = 0; c < 32; c++) begin
      v = 16'(c * 16'h0101);
      drive(0, 1, c, v);
    end
    for (int c = 0; c < 32; c++) begin
      v = 16'(c * 16'h0101);
      drive(0, 1, c, v + 16'd1);
      #1 check("pass2_old", dout32, v);
    end
    for (int c = 0; c < 32; c++) begin
      drive(0, 0, c, 16'h0);
    end
    drive(0, 0, 7, 16'h0);
    #1 check("ch7_pass2", dout32, 16'h0708);

    // Reset together with a write: the write is lost
    drive(1, 1, 3, 16'hFFFF);
    drive(0, 0, 3, 16'h0);
    #1 check("rst_beats_en", dout32, 16'h0220);
    drive(0, 0, 7, 16'h0);
    #1 check("rst_clears", dout32, 16'h0220);

    // Out-of-range write on the 24-channel instance
    drive(0, 1, 30, 16'hAAAA);
    #1 check("oor_same", dout24, 16'h0220);
    drive(0, 0, 30, 16'h0);
    #1 check("oor_read24", dout24, 16'h0220);
    #1 check("oor_read32", dout32, 16'hAAAA);
    for (int c = 0; c < 32; c++) begin
      drive(0, 0, c, 16'h0);
    end

    // Random traffic with scan pins toggling
    for (int n = 0; n < 600; n++) begin
      drive(($urandom_range(0, 49) == 0), $urandom_range(0, 1),
            $urandom_range(0, 31), 16'($urandom));
      scan_in     = 5'($urandom);
      scan_enable = 1'($urandom);
      test_mode   = 1'($urandom);
    end
    drive(0, 0, 0, 16'h0);
    @(posedge clk);
    #1;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
